// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and types for the MIPS-style register file.
//   DATA_W   - register width in bits
//   ADDR_W   - register address width
//   NUM_REGS - number of architectural registers (2**ADDR_W)
//   ZERO_REG - address of the hardwired-zero register
package reg_file_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// reg_file_rd_port: one combinational read port of the register file.
// Selects the addressed register, forces register 0 to read zero and
// forces zero while the file is in reset.
// Optional feature (macro REG_FILE_BYPASS_EN): write-through forwarding,
// the port returns the write data of a same-cycle write to the same
// register instead of the stored contents.
// Ports:
//   rst   in   reset, forces the output to zero
//   rn    in   read address
//   regs  in   storage array of the register file
//   wrEn  in   a qualified write is pending this cycle (RegWrite && WN!=0)
//   wn    in   write address
//   wd    in   write data
//   rd    out  read data
module reg_file_rd_port #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              rst,
  input  logic [ADDR_W-1:0] rn,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wn,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

`ifndef REG_FILE_BYPASS_EN
  // Write-side inputs only matter when forwarding is built in.
  logic unusedBypass;
  assign unusedBypass = ^{wrEn, wn, wd};
`endif

  always_comb begin
    rd = regs[rn];
    if (rn == ZERO_ADDR) begin
      rd = '0;
    end
`ifdef REG_FILE_BYPASS_EN
    // wrEn already excludes register 0, so r0 can never be forwarded.
    else if (wrEn && (wn == rn)) begin
      rd = wd;
    end
`endif
    // Reset overrides forwarding so the outputs read zero throughout reset.
    if (rst) begin
      rd = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: MIPS-style general-purpose register file.
// 2**ADDR_W registers of DATA_W bits, two combinational read ports and one
// write port clocked on the rising edge of clk. Register 0 reads zero.
// Optional feature (macro REG_FILE_BYPASS_EN): write-through forwarding
// from the write port to both read ports in the same cycle.
// Ports:
//   clk       in   system clock, writes on rising edge
//   rst       in   asynchronous active-high reset, clears every register
//   RegWrite  in   write enable
//   RN1, RN2  in   read addresses
//   WN        in   write address
//   WD        in   write data
//   RD1, RD2  out  read data
module reg_file #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RN1,
  input  logic [ADDR_W-1:0] RN2,
  input  logic [ADDR_W-1:0] WN,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wrEn;

  // An X on WN makes this compare X, which the if below treats as false,
  // so an unknown write address never corrupts storage.
  assign wrEn = RegWrite && (WN != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wrEn) begin
      regs[WN] <= WD;
    end
  end

  reg_file_rd_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) rdPort1 (
    .rst (rst),
    .rn  (RN1),
    .regs(regs),
    .wrEn(wrEn),
    .wn  (WN),
    .wd  (WD),
    .rd  (RD1)
  );

  reg_file_rd_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) rdPort2 (
    .rst (rst),
    .rn  (RN2),
    .regs(regs),
    .wrEn(wrEn),
    .wn  (WN),
    .wd  (WD),
    .rd  (RD2)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file.
// Directed scenarios with literal expectations, then randomized traffic
// compared every cycle against an array model of the register file.
// Honours REG_FILE_BYPASS_EN to match the build of the design.
module tb_reg_file;
  import reg_file_pkg::*;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst;
  logic      RegWrite;
  reg_addr_t RN1, RN2, WN;
  reg_data_t WD, RD1, RD2;

  reg_data_t model [NUM_REGS];
  bit        checkEn = 1'b0;
  int        passCnt = 0;
  int        totalCnt = 0;

  reg_file dut (
    .clk     (clk),
    .rst     (rst),
    .RegWrite(RegWrite),
    .RN1     (RN1),
    .RN2     (RN2),
    .WN      (WN),
    .WD      (WD),
    .RD1     (RD1),
    .RD2     (RD2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input reg_data_t act, input reg_data_t exp);
    totalCnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at t=%0t",
               name, act, act, exp, exp, $time);
    end else begin
      passCnt++;
    end
  endtask

  // What a read port must show given the model and the current inputs.
  function automatic reg_data_t expRead(input reg_addr_t rn);
    if (rst) return '0;
    if (rn == 0) return '0;
    if (BYP && RegWrite && (WN == rn)) return WD;
    return model[rn];
  endfunction

  // Drive a write request, let one rising edge pass, update the model.
  task automatic doWrite(input logic we, input reg_addr_t wn, input reg_data_t wd);
    RegWrite = we;
    WN       = wn;
    WD       = wd;
    @(posedge clk);
    if (we && (wn != 0) && !rst) model[wn] = wd;
    #1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask

  // Per-cycle comparison during randomized traffic, away from the write edge.
  always @(negedge clk) begin
    if (checkEn) begin
      check("rand_RD1", RD1, expRead(RN1));
      check("rand_RD2", RD2, expRead(RN2));
    end
  end

  initial begin
    rst      = 1'b1;
    RegWrite = 1'b0;
    RN1      = '0;
    RN2      = '0;
    WN       = '0;
    WD       = '0;
    clearModel();

    // Reset state on both ports.
    #2;
    RN1 = 5'd1;
    RN2 = 5'd31;
    #1;
    check("reset_RD1", RD1, 32'd0);
    check("reset_RD2", RD2, 32'd0);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic writes on consecutive edges, then combinational read-back.
    doWrite(1'b1, 5'd1, 32'd200);
    doWrite(1'b1, 5'd7, 32'd300);
    RegWrite = 1'b0;
    RN1 = 5'd1;
    RN2 = 5'd7;
    #1;
    check("basic_RD1", RD1, 32'd200);
    check("basic_RD2", RD2, 32'd300);
    RN1 = 5'd7;
    #1;
    check("same_reg_RD1", RD1, 32'd300);
    check("same_reg_RD2", RD2, 32'd300);

    // Write to r0 is dropped.
    doWrite(1'b1, 5'd0, 32'hDEADBEEF);
    RegWrite = 1'b0;
    RN1 = 5'd0;
    #1;
    check("zero_reg", RD1, 32'd0);

    // Disabled write leaves r1 intact.
    doWrite(1'b0, 5'd1, 32'd999);
    RN1 = 5'd1;
    #1;
    check("write_disable", RD1, 32'd200);

    // Read during write to the same register.
    RN1      = 5'd7;
    RegWrite = 1'b1;
    WN       = 5'd7;
    WD       = 32'd555;
    #1;
    check("rdw_before_edge", RD1, BYP ? 32'd555 : 32'd300);
    @(posedge clk);
    model[7] = 32'd555;
    #1;
    RegWrite = 1'b0;
    #1;
    check("rdw_after_edge", RD1, 32'd555);

    // Randomized traffic against the model.
    checkEn = 1'b1;
    for (int n = 0; n < 300; n++) begin
      reg_addr_t wa;
      wa  = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      RN1 = ($urandom_range(0, 3) == 0) ? wa : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      RN2 = ($urandom_range(0, 3) == 0) ? wa : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      doWrite(logic'($urandom_range(0, 3) != 0), wa, reg_data_t'($urandom));
    end
    checkEn  = 1'b0;
    RegWrite = 1'b0;

    // Reset asserted between edges clears everything at once.
    doWrite(1'b1, 5'd5, 32'h1234_5678);
    RegWrite = 1'b0;
    RN1 = 5'd5;
    #1;
    check("pre_reset_r5", RD1, 32'h1234_5678);
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_r5", RD1, 32'd0);
    clearModel();
    for (int i = 0; i < NUM_REGS; i++) begin
      RN1 = reg_addr_t'(i);
      RN2 = reg_addr_t'(NUM_REGS - 1 - i);
      #1;
      check("reset_all_RD1", RD1, 32'd0);
      check("reset_all_RD2", RD2, 32'd0);
    end
    // Write attempted while reset is held is ignored.
    doWrite(1'b1, 5'd9, 32'd77);
    RegWrite = 1'b0;
    RN1 = 5'd9;
    #1;
    check("write_in_reset", RD1, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // First write after reset release.
    doWrite(1'b1, 5'd3, 32'd42);
    RegWrite = 1'b0;
    RN1 = 5'd3;
    RN2 = 5'd5;
    #1;
    check("post_reset_r3", RD1, 32'd42);
    check("post_reset_r5", RD2, 32'd0);
    RN2 = 5'd9;
    #1;
    check("post_reset_r9", RD2, 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
